requant_writeback: RTL
======================

# requant_writeback

Downstream stage of the linear-layer controller. After a layer finishes, it streams the NUM_NEURONS signed 2·DATA_WIDTH accumulator results out of the result BRAM. Each result is requantized with a per-layer multiplier, a rounding right shift, saturation and an optional ReLU. The DATA_WIDTH results are written into the token BRAM consumed by the next layer, so layers can be chained without host involvement.

## Interface
- ADDR_WIDTH, 10: BRAM address width.
- DATA_WIDTH, 16: token width; accumulator width is 2·DATA_WIDTH.
- NUM_NEURONS, 16: results per layer; must be ≥2 and a power of two.
- BRAM_LATENCY, 3: result-BRAM read latency in cycles; must be ≥1.
- clk  in  1  sole clock; rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; ignored while busy.
- scale_mult  in  DATA_WIDTH  signed multiplier; sampled on accepted start.
- scale_shift  in  6  right-shift amount 0..63; sampled on accepted start.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when the last write has issued.
- acc_rd_en  out  1  result-BRAM read enable.
- acc_rd_addr  out  ADDR_WIDTH  result index, zero-extended.
- acc_rd_data  in  2·DATA_WIDTH  signed accumulator.
- tok_wr_en  out  1  token-BRAM write enable.
- tok_wr_addr  out  ADDR_WIDTH  token index; equals the result index.
- tok_wr_data  out  DATA_WIDTH  signed requantized token.
- sat_cnt  out  $clog2(NUM_NEURONS)+1  count of clamped outputs in the current or last run.

## Operation
- FSM states: IDLE → ISSUE → DRAIN → FIN → IDLE.
- IDLE: start=1 latches scale_mult/scale_shift, clears the read index and sat_cnt, then goes to ISSUE.
- ISSUE: acc_rd_en=1 with acc_rd_addr=index for exactly NUM_NEURONS consecutive cycles (0..NUM_NEURONS-1), then DRAIN.
- DRAIN: waits until the valid pipeline is empty, then FIN.
- FIN: done=1 for one cycle, then IDLE.
- Datapath, per element:
  - p = acc × mult, signed, full 3·DATA_WIDTH width.
  - If shift>0: r = (p + 2^(shift-1)) >>> shift, arithmetic, round-half-up. If shift=0: r = p.
  - Shifts ≥ 3·DATA_WIDTH behave as 3·DATA_WIDTH−1.
  - Saturate r to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - Any clamp increments sat_cnt, including ReLU zeroing (see Configuration).
- Token addresses leave in strictly increasing order, one write per result, with no gaps.
- start while busy has no effect. Latched scale values stay constant for the whole run.
- Reset mid-run: all state clears to IDLE immediately; no further reads or writes.

## Timing
- Reset values: busy=0, done=0, acc_rd_en=0, acc_rd_addr=0, tok_wr_en=0, tok_wr_addr=0, tok_wr_data=0, sat_cnt=0.
- busy rises the cycle after start is accepted. It falls in the same cycle done is high.
- Read of index i issued in cycle t. Data sampled at t+BRAM_LATENCY.
- Datapath pipeline:
  - Product registered at t+BRAM_LATENCY+1.
  - Rounded shift registered at t+BRAM_LATENCY+2.
  - Saturated result drives registered tok_wr_* in cycle t+BRAM_LATENCY+3.
- Write of index i is in cycle t_i+L, with L = BRAM_LATENCY+3.
- First read is in the cycle after start, so the run lasts NUM_NEURONS+L+1 cycles from start to done.
- done coincides with the cycle after the final write.
- A new start is accepted in the cycle after done. Back-to-back runs are therefore possible.
- The valid token pipeline is a shift register of length L fed by acc_rd_en. tok_wr_en is its last stage.

## Configuration
- REQUANT_RELU_EN defined: after saturation, negative results become 0 and count as clamped. Outputs are in [0, 2^(DATA_WIDTH−1)−1].
- REQUANT_RELU_EN undefined: signed saturation only. Negative outputs pass through.

## Structure
- Package quant_pkg holds:
  - Typedefs acc_t (2·DATA_WIDTH signed), prod_t (3·DATA_WIDTH signed), tok_t.
  - Constants TOK_MAX and TOK_MIN.
  - The FSM state enum.
- Sub-module requant_pipe: the three-stage multiply/round/saturate datapath, carrying valid/index sideband and a per-element clamp flag.
- The top level owns the FSM, read counter, valid alignment and sat_cnt.

## Test plan
All scenarios use the default parameters; the BRAM model has a 3-cycle latency.
- Identity: results[i]=i−8, mult=1, shift=0.
  - Without REQUANT_RELU_EN: tokens −8..7, sat_cnt=0.
  - With REQUANT_RELU_EN: negatives become 0, sat_cnt=8.
- Rounding: acc=5, mult=3, shift=2 → 15/4 = 3.75 → token 4. acc=−6, mult=1, shift=2 → −1.5 rounds to −1.
- Saturation: acc=0x0001_0000, mult=2, shift=0 → 32767. acc=−0x0001_0000 → −32768. sat_cnt counts both.
- Timing: start pulse in cycle 0:
  - First acc_rd_en in cycle 1.
  - First tok_wr_en in cycle 7.
  - Last write in cycle 22.
  - done in cycle 23.
  - busy high cycles 1..22.
- Interference: start held high throughout a run, and scale inputs changed mid-run → exactly 16 writes using the original scale. A second run starts from the start seen in cycle 24.
- Reset: rst asserted low in cycle 10 of a run → all outputs 0 and no writes until the next start; the next run completes normally.

Source files
------------

// File: rtl/quant_pkg.sv
// rtl/quant_pkg.sv - shared widths, data types and FSM states for requant_writeback
package quant_pkg;

  localparam int QUANT_DW = 16;
  localparam int PROD_W   = 3 * QUANT_DW;

  typedef logic signed [2*QUANT_DW-1:0] acc_t;
  typedef logic signed [PROD_W-1:0]     prod_t;
  typedef logic signed [QUANT_DW-1:0]   tok_t;

  localparam tok_t TOK_MAX = {1'b0, {(QUANT_DW-1){1'b1}}};
  localparam tok_t TOK_MIN = {1'b1, {(QUANT_DW-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FIN
  } state_t;

endpackage

// File: rtl/requant_writeback_if.sv
// rtl/requant_writeback_if.sv - result-BRAM read port and token-BRAM write port bundle
interface requant_writeback_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
);

  logic                            acc_rd_en;
  logic [ADDR_WIDTH-1:0]           acc_rd_addr;
  logic signed [2*DATA_WIDTH-1:0]  acc_rd_data;
  logic                            tok_wr_en;
  logic [ADDR_WIDTH-1:0]           tok_wr_addr;
  logic signed [DATA_WIDTH-1:0]    tok_wr_data;

  modport master (
    output acc_rd_en, acc_rd_addr,
    input  acc_rd_data,
    output tok_wr_en, tok_wr_addr, tok_wr_data
  );

  modport slave (
    input  acc_rd_en, acc_rd_addr,
    output acc_rd_data,
    input  tok_wr_en, tok_wr_addr, tok_wr_data
  );

endinterface

// File: rtl/requant_pipe.sv
// rtl/requant_pipe.sv - multiply/round/saturate datapath; REQUANT_RELU_EN adds ReLU after saturation
module requant_pipe
  import quant_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  input  acc_t             in_acc,
  input  tok_t             mult,
  input  logic [5:0]       shift,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output tok_t             out_tok,
  output logic             out_clamp,
  output logic             inner_busy
);

  localparam logic [5:0] SH_MAX = 6'(PROD_W - 1);

  logic             s1_valid, s2_valid;
  logic [IDX_W-1:0] s1_idx, s2_idx;
  prod_t            s1_prod, s2_rnd;
  logic [5:0]       sh_eff;
  logic signed [PROD_W:0] rnd_bias, rnd_sum, rnd_shifted;
  tok_t             sat_tok;
  logic             sat_clamp;

  // Stage 1: full-width signed product of accumulator and multiplier
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_prod  <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_idx  <= in_idx;
        s1_prod <= prod_t'(in_acc) * prod_t'(mult);
      end
    end
  end

  // Round-half-up bias; one extra bit keeps the bias add from overflowing at the largest shift
  always_comb begin
    sh_eff   = (shift > SH_MAX) ? SH_MAX : shift;
    rnd_bias = '0;
    if (sh_eff != 6'd0) rnd_bias[sh_eff - 6'd1] = 1'b1;
    rnd_sum     = (PROD_W+1)'(s1_prod) + rnd_bias;
    rnd_shifted = rnd_sum >>> sh_eff;
  end

  // Stage 2: register the rounded, arithmetically shifted value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_idx   <= '0;
      s2_rnd   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_idx <= s1_idx;
        s2_rnd <= prod_t'(rnd_shifted);
      end
    end
  end

  // Clamp to token range and flag any element that was altered
  always_comb begin
    sat_tok   = s2_rnd[QUANT_DW-1:0];
    sat_clamp = 1'b0;
    if (s2_rnd > prod_t'(TOK_MAX)) begin
      sat_tok   = TOK_MAX;
      sat_clamp = 1'b1;
    end else if (s2_rnd < prod_t'(TOK_MIN)) begin
      sat_tok   = TOK_MIN;
      sat_clamp = 1'b1;
    end
`ifdef REQUANT_RELU_EN
    if (sat_tok[QUANT_DW-1]) begin
      sat_tok   = '0;
      sat_clamp = 1'b1;
    end
`endif
  end

  // Stage 3: registered token write outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_tok   <= '0;
      out_clamp <= 1'b0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_idx   <= s2_idx;
        out_tok   <= sat_tok;
        out_clamp <= sat_clamp;
      end
    end
  end

  assign inner_busy = s1_valid | s2_valid;

endmodule

// File: rtl/requant_writeback.sv
// rtl/requant_writeback.sv - streams accumulators out, requantizes them and writes tokens back
module requant_writeback
  import quant_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = QUANT_DW,
  parameter int NUM_NEURONS  = 16,
  parameter int BRAM_LATENCY = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic signed [DATA_WIDTH-1:0]  scale_mult,
  input  logic [5:0]                    scale_shift,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(NUM_NEURONS):0]  sat_cnt,
  requant_writeback_if.master           bus
);

  localparam int               IDX_W    = $clog2(NUM_NEURONS);
  localparam int               SAT_W    = IDX_W + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NEURONS - 1);

  state_t                 state;
  logic                   rd_en;
  logic [IDX_W-1:0]       rd_idx;
  tok_t                   mult_q;
  logic [5:0]             shift_q;
  logic [BRAM_LATENCY-1:0] al_v;
  logic [IDX_W-1:0]       al_idx [BRAM_LATENCY];
  logic                   wr_v, wr_clamp, pipe_busy, pipe_pending;
  logic [IDX_W-1:0]       wr_idx;
  tok_t                   wr_tok;

  assign pipe_pending = (|al_v) | pipe_busy;

  // Run control: latch scale, issue NUM_NEURONS reads, drain the pipeline, pulse done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_idx  <= '0;
      mult_q  <= '0;
      shift_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mult_q  <= tok_t'(scale_mult);
            shift_q <= scale_shift;
            rd_idx  <= '0;
            rd_en   <= 1'b1;
            busy    <= 1'b1;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rd_idx <= rd_idx + IDX_W'(1);
          if (rd_idx == IDX_LAST) begin
            rd_en <= 1'b0;
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Only the final write stage may still be occupied: done lands right after it
          if (!pipe_pending) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_FIN;
          end
        end
        ST_FIN: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Delay read valid/index to the cycle the BRAM returns the matching data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      al_v <= '0;
      for (int k = 0; k < BRAM_LATENCY; k++) al_idx[k] <= '0;
    end else begin
      al_v[0]   <= rd_en;
      al_idx[0] <= rd_idx;
      for (int k = 1; k < BRAM_LATENCY; k++) begin
        al_v[k]   <= al_v[k-1];
        al_idx[k] <= al_idx[k-1];
      end
    end
  end

  // Clamp counter, cleared when a run is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_cnt <= '0;
    end else if (state == ST_IDLE && start) begin
      sat_cnt <= '0;
    end else if (wr_v && wr_clamp) begin
      sat_cnt <= sat_cnt + SAT_W'(1);
    end
  end

  requant_pipe #(.IDX_W(IDX_W)) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (al_v[BRAM_LATENCY-1]),
    .in_idx     (al_idx[BRAM_LATENCY-1]),
    .in_acc     (acc_t'(bus.acc_rd_data)),
    .mult       (mult_q),
    .shift      (shift_q),
    .out_valid  (wr_v),
    .out_idx    (wr_idx),
    .out_tok    (wr_tok),
    .out_clamp  (wr_clamp),
    .inner_busy (pipe_busy)
  );

  assign bus.acc_rd_en   = rd_en;
  assign bus.acc_rd_addr = ADDR_WIDTH'(rd_idx);
  assign bus.tok_wr_en   = wr_v;
  assign bus.tok_wr_addr = ADDR_WIDTH'(wr_idx);
  assign bus.tok_wr_data = wr_tok;

endmodule
